// File: rtl/alu_dr_pkg.sv
// Shared definitions for the dual-rail ALU stage: rail codes, opcodes, FSM states
// and the single-bit dual-rail encoder.
package alu_dr_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_EXEC = 2'd1,
    S_DATA = 2'd2,
    S_RTZ  = 2'd3
  } state_t;

  function automatic logic [1:0] dr_enc(input logic bit_v);
    return bit_v ? DR_1 : DR_0;
  endfunction

endpackage

// File: rtl/alu_dr_nbits_decode.sv
// Dual-rail to binary decoder: W rail pairs become a W-bit value plus wavefront
// status (complete, all-NULL, any illegal pair).
module dr_decode
  import alu_dr_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2*W-1:0] rails,
  output logic [W-1:0]   value,
  output logic           complete,
  output logic           all_null,
  output logic           illegal
);

  always_comb begin
    value    = '0;
    complete = 1'b1;
    all_null = 1'b1;
    illegal  = 1'b0;
    for (int i = 0; i < W; i++) begin
      value[i] = rails[2*i+1];
      if (rails[2*i +: 2] == DR_ILL) illegal = 1'b1;
      if ((rails[2*i +: 2] != DR_0) && (rails[2*i +: 2] != DR_1)) complete = 1'b0;
      if (rails[2*i +: 2] != DR_NULL) all_null = 1'b0;
    end
  end

endmodule

// File: rtl/alu_dr_nbits.sv
// N-bit dual-rail ALU stage with a 4-phase ko/ki handshake. Outputs are registered
// from the FSM state, so they follow a state change by one clock.
module alu_dr_nbits
  import alu_dr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  input  logic [3:0]     opr,
  input  logic           ki,
  output logic [2*N-1:0] soma,
  output logic [1:0]     of,
  output logic [1:0]     neg,
  output logic [1:0]     zero,
  output logic           ko,
  output logic           err
);

  logic [N-1:0] a_val, b_val;
  logic [1:0]   o_val;
  logic         a_cmp, b_cmp, o_cmp;
  logic         a_nul, b_nul, o_nul;
  logic         a_ill, b_ill, o_ill;

  dr_decode #(.W(N)) u_dec_a (
    .rails(a), .value(a_val), .complete(a_cmp), .all_null(a_nul), .illegal(a_ill)
  );

  dr_decode #(.W(N)) u_dec_b (
    .rails(b), .value(b_val), .complete(b_cmp), .all_null(b_nul), .illegal(b_ill)
  );

  dr_decode #(.W(2)) u_dec_op (
    .rails(opr), .value(o_val), .complete(o_cmp), .all_null(o_nul), .illegal(o_ill)
  );

  logic in_complete, in_null, in_illegal;
  assign in_complete = a_cmp & b_cmp & o_cmp;
  assign in_null     = a_nul & b_nul & o_nul;
  assign in_illegal  = a_ill | b_ill | o_ill;

  state_t       state;
  logic         blocked;
  logic [N-1:0] a_q, b_q;
  op_t          op_q;
  logic [N-1:0] res_q;
  logic         ovf_q;

  logic [N-1:0]   alu_res;
  logic           alu_ovf;
  logic [2*N-1:0] res_dr;

  // Overflow only has meaning for add/sub; logic ops report DATA0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = a_q + b_q;
        alu_ovf = (a_q[N-1] == b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_ovf = (a_q[N-1] != b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      default: alu_res = a_q ^ b_q;
    endcase
  end

  always_comb begin
    res_dr = '0;
    for (int i = 0; i < N; i++) res_dr[2*i +: 2] = dr_enc(res_q[i]);
  end

  // blocked holds off capture after an illegal pair until an all-NULL wavefront arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_WAIT;
      ko      <= 1'b0;
      err     <= 1'b0;
      blocked <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      soma    <= '0;
      of      <= DR_NULL;
      neg     <= DR_NULL;
      zero    <= DR_NULL;
    end else begin
      if (ko && in_null) ko <= 1'b0;

      if (state == S_DATA) begin
        soma <= res_dr;
        of   <= dr_enc(ovf_q);
        neg  <= dr_enc(res_q[N-1]);
        zero <= dr_enc(res_q == '0);
      end else begin
        soma <= '0;
        of   <= DR_NULL;
        neg  <= DR_NULL;
        zero <= DR_NULL;
      end

      unique case (state)
        S_WAIT: begin
          if (blocked) begin
            if (in_null) blocked <= 1'b0;
          end else if (in_illegal) begin
            err     <= 1'b1;
            blocked <= 1'b1;
          end else if (in_complete) begin
            a_q   <= a_val;
            b_q   <= b_val;
            op_q  <= op_t'(o_val);
            ko    <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q <= alu_res;
          ovf_q <= alu_ovf;
          state <= S_DATA;
        end
        S_DATA: begin
          if (ki) state <= S_RTZ;
        end
        default: begin
          if (!ko && !ki) state <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dr_nbits.sv
// Scoreboard bench for alu_dr_nbits: directed tokens push expected results, a
// negedge monitor pops and compares whenever a DATA wavefront appears on soma.
module tb_alu_dr_nbits;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic [3:0] opr;
  logic       ki;
  logic [7:0] soma;
  logic [1:0] of, neg, zero;
  logic       ko, err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] soma;
    logic [1:0] of;
    logic [1:0] neg;
    logic [1:0] zero;
  } exp_t;

  exp_t exp_q[$];
  logic prev_data = 1'b0;

  alu_dr_nbits #(.N(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .opr(opr), .ki(ki),
    .soma(soma), .of(of), .neg(neg), .zero(zero), .ko(ko), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb,
                               input logic [3:0] top, input logic tki);
    @(posedge clk);
    #1;
    a   = ta;
    b   = tb;
    opr = top;
    ki  = tki;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a NULL->DATA transition on soma is one result token.
  always @(negedge clk) begin
    if (rst) begin
      prev_data = 1'b0;
    end else begin
      if ((soma != 8'h00) && !prev_data) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL monitor_unexpected actual=%b_%b_%b_%b expected=none",
                   soma, of, neg, zero);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({soma, of, neg, zero} !== e) begin
            failures++;
            $display("[TB] FAIL monitor_result actual=%b_%b_%b_%b expected=%b_%b_%b_%b",
                     soma, of, neg, zero, e.soma, e.of, e.neg, e.zero);
          end
        end
      end
      prev_data = (soma != 8'h00);
    end
  end

  // One full token: DATA in, result out, ki up, NULL back, ki down.
  // With hold set the inputs stay DATA through RTZ before returning to NULL.
  task automatic run_token(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top,
                           input logic [7:0] esoma, input logic [1:0] eof,
                           input logic [1:0] eneg, input logic [1:0] ezero, input logic hold);
    exp_t e;
    e.soma = esoma;
    e.of   = eof;
    e.neg  = eneg;
    e.zero = ezero;
    exp_q.push_back(e);
    applyStimulus(ta, tb, top, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ko_rise", 32'(ko), 32'd1);
    @(negedge clk);
    checkOutput("exec_soma_null", 32'(soma), 32'd0);
    @(negedge clk);
    applyStimulus(hold ? ta : 8'h00, hold ? tb : 8'h00, hold ? top : 4'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ki_soma_still_data", 32'(soma == esoma), 32'd1);
    checkOutput("ko_after_ki", 32'(ko), 32'(hold));
    @(negedge clk);
    checkOutput("rtz_soma_null", 32'(soma), 32'd0);
    checkOutput("rtz_flags_null", 32'({of, neg, zero}), 32'd0);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checkOutput("rtz_hold_ko", 32'(ko), 32'd1);
        checkOutput("rtz_hold_soma", 32'(soma), 32'd0);
      end
    end
    applyStimulus(8'h00, 8'h00, 4'h0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a   = 8'h00;
    b   = 8'h00;
    opr = 4'h0;
    ki  = 1'b0;
    #2;
    checkOutput("reset_soma", 32'(soma), 32'd0);
    checkOutput("reset_flags", 32'({of, neg, zero}), 32'd0);
    checkOutput("reset_ko", 32'(ko), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 3+4, 3-4, 7+1 (overflow), -8-1 (overflow), 6&3, 5^5 (zero, held in RTZ)
    run_token(8'b01011010, 8'b01100101, 4'b0101, 8'b01101010, 2'b01, 2'b01, 2'b01, 1'b0);
    run_token(8'b01011010, 8'b01100101, 4'b0110, 8'b10101010, 2'b01, 2'b10, 2'b01, 1'b0);
    run_token(8'b01101010, 8'b01010110, 4'b0101, 8'b10010101, 2'b10, 2'b10, 2'b01, 1'b0);
    run_token(8'b10010101, 8'b01010110, 4'b0110, 8'b01101010, 2'b10, 2'b01, 2'b01, 1'b0);
    run_token(8'b01101001, 8'b01011010, 4'b1001, 8'b01011001, 2'b01, 2'b01, 2'b01, 1'b0);
    run_token(8'b01100110, 8'b01100110, 4'b1010, 8'b01010101, 2'b01, 2'b01, 2'b10, 1'b1);

    // Illegal pair arrives while still in RTZ, then is seen again in WAIT
    applyStimulus(8'b11011010, 8'b01100101, 4'b0101, 1'b0);
    @(negedge clk);
    checkOutput("ko_cleared_in_rtz", 32'(ko), 32'd0);
    @(negedge clk);
    checkOutput("err_ignored_in_rtz", 32'(err), 32'd0);
    @(negedge clk);
    checkOutput("err_set", 32'(err), 32'd1);
    checkOutput("illegal_ko", 32'(ko), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("illegal_soma_null", 32'(soma), 32'd0);
    checkOutput("illegal_ko_held", 32'(ko), 32'd0);
    applyStimulus(8'h00, 8'h00, 4'h0, 1'b0);
    @(negedge clk);
    run_token(8'b01011001, 8'b01100110, 4'b0101, 8'b01101010, 2'b01, 2'b01, 2'b01, 1'b0);
    checkOutput("err_sticky", 32'(err), 32'd1);

    // Partial wavefront: opr logical bit 1 left NULL
    applyStimulus(8'b01011010, 8'b01100101, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("partial_ko", 32'(ko), 32'd0);
      checkOutput("partial_soma", 32'(soma), 32'd0);
    end
    applyStimulus(8'h00, 8'h00, 4'h0, 1'b0);
    @(negedge clk);

    // Asynchronous reset while the result is on the outputs
    begin
      exp_t e;
      e.soma = 8'b01101010;
      e.of   = 2'b01;
      e.neg  = 2'b01;
      e.zero = 2'b01;
      exp_q.push_back(e);
    end
    applyStimulus(8'b01011010, 8'b01100101, 4'b0101, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_soma_data", 32'(soma), 32'b01101010);
    #2;
    rst = 1'b1;
    a   = 8'h00;
    b   = 8'h00;
    opr = 4'h0;
    #1;
    checkOutput("async_rst_soma", 32'(soma), 32'd0);
    checkOutput("async_rst_ko", 32'(ko), 32'd0);
    checkOutput("async_rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_soma", 32'(soma), 32'd0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
